big_number_mod_reduce: RTL and testbench
========================================

# big_number_mod_reduce

Limb-serial conditional modular subtraction stage that sits directly downstream of `big_number_addition`. It consumes the 3328-bit sum `c` on that block's `en_out` pulse and produces `r = (c >= M) ? c - M : c`. One 256-bit limb is processed per clock with a registered borrow chain, so no full-width carry path exists. It completes the modular addition `(a + b) mod M` for operands `a, b < M`.

## Interface
- `Size_add`, 3328, total operand width in bits
- `number_of_limbs`, 13, number of limbs; `Size_add = number_of_limbs * limb_size`
- `limb_size`, 256, width of one subtraction limb

- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset: asynchronous, active-low
- `en`  in  1  start pulse; driven by the adder's `en_out`
- `sum`  in  Size_add  value to reduce; sampled only on the accepted `en` cycle
- `modulus`  in  Size_add  M; sampled with `sum`
- `busy`  out  1  high while a reduction is in progress
- `r`  out  Size_add  reduced result; holds until the next completion
- `en_out`  out  1  one-cycle pulse; `r` is valid while it is high

## Operation
- FSM states:
  - IDLE (reset)
  - SUB
  - DONE
- IDLE, `en`=1 → capture `sum` into `s_reg` and `modulus` into `m_reg`. Set `borrow`=0 and `idx`=0. Go to SUB.
- IDLE, `en`=0 → stay in IDLE.
- SUB, each cycle:
  - Compute the 257-bit `d = {1'b0, s_reg[idx]} - {1'b0, m_reg[idx]} - borrow`.
  - Write `d_reg[idx] <= d[255:0]` and `borrow <= d[256]`.
  - If `idx` = `number_of_limbs`-1 → go to DONE. Otherwise `idx <= idx+1`.
- DONE:
  - `r <= borrow ? s_reg : d_reg`, using the final borrow, which means `sum < M`.
  - `en_out <= 1` for exactly one cycle.
  - Go to IDLE.
- Width rule: inputs must satisfy `M < 2^(Size_add-1)` and `sum < 2M`, so the result never needs a second subtraction. The block does not check this range. For out-of-range input, the block produces the single conditional subtraction and nothing more.
- `en` while `busy`=1 is ignored. There is no queueing and no error flag.
- `sum` and `modulus` may change freely after the accepted `en` cycle.
- `busy` = (state != IDLE). It is registered and decoded from state only.
- Reset mid-operation aborts the operation. All registers go to 0 immediately and no `en_out` is produced.
- Reset values:
  - `busy`=0, `en_out`=0, `r`=0
  - state=IDLE, `idx`=0, `borrow`=0
  - `s_reg`, `m_reg`, `d_reg` = 0

## Timing
- `en` sampled at edge E0. SUB occupies edges E1..E13, with limb k at edge E(k+1). DONE updates `r` and `en_out` at edge E14.
- Latency: `en_out` is high in the cycle following E14, i.e. 14 clocks after `en` is sampled. The latency is fixed and data-independent.
- Back-to-back: `en` may be reasserted in the same cycle `en_out` is high, because the state is IDLE then. Maximum throughput is one result per 15 cycles.
- This exceeds the adder's own 3-cycle issue interval. Upstream must hold off until `busy`=0.
- `busy` rises at E0 and falls at E14, so it is high for 14 cycles.
- `r` changes only at a DONE edge or at reset. It is stable at all other times.

## Structure
- Shared package `bignum_pkg` holds:
  - the constants `SIZE_ADD`=3328, `LIMB_SIZE`=256, `NUM_LIMBS`=13
  - `IDX_W`=$clog2(NUM_LIMBS)
  - the FSM state encoding typedef
  - The adder stage imports the same constants.
- One sub-module, `limb_subtractor`: combinational, `#(size=256)`.
  - Inputs: `a[size-1:0]`, `b[size-1:0]`, `bin`.
  - Output: `d[size:0] = {1'b0,a} - {1'b0,b} - bin`, with `d[size]` as the borrow out.
  - Instantiate it once. The block muxes its operands by `idx`.
- Store `s_reg`, `m_reg` and `d_reg` as limb arrays `[NUM_LIMBS-1:0][LIMB_SIZE-1:0]`.

## Test plan
- Reset/idle: assert `rst_n`=0 with random inputs → `r`=0, `en_out`=0, `busy`=0. Hold `en`=0 for 50 cycles → no `en_out`.
- Basic reduce: M=1000, sum=1500, pulse `en` → `busy` high for 14 cycles, `en_out` 14 clocks later, `r`=500. With sum=999 → `r`=999. With sum=1000 → `r`=0.
- Cross-limb borrow: M=1, sum=2^256 → `r`=2^256-1 (borrow ripples through limb 0). Then M=2^3326+1, sum=2^3326 → `r`=sum (final borrow taken).
- Busy collision: pulse `en` with sum=1500, M=1000; pulse `en` again at cycle 5 with sum=7 → exactly one `en_out`, `r`=500, second request dropped.
- Back-to-back plus reset: issue a second `en` in the `en_out` cycle → second result 14 clocks later. Start a third request, drop `rst_n` at cycle 7 → no `en_out`, `r`=0 immediately, the next request completes normally.
- Chained with adder: random a, b < M drive `big_number_addition` with its `en_out` → `en`, for 1000 trials → each `r` = (a+b) mod M against a reference model.

Source files
------------

// File: rtl/bignum_pkg.sv
// Shared constants and FSM encoding for the big-number adder/reducer datapath.
package bignum_pkg;
    localparam int SIZE_ADD  = 3328;
    localparam int LIMB_SIZE = 256;
    localparam int NUM_LIMBS = 13;
    localparam int IDX_W     = $clog2(NUM_LIMBS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;
endpackage

// File: rtl/limb_subtractor.sv
// One-limb subtract with borrow in/out; d[size] is the borrow out.
module limb_subtractor #(
    parameter int size = 256
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            bin,
    output logic [size:0]   d
);
    assign d = {1'b0, a} - {1'b0, b} - {{size{1'b0}}, bin};
endmodule

// File: rtl/big_number_mod_reduce.sv
// Limb-serial conditional subtraction: r = (sum >= modulus) ? sum - modulus : sum.
module big_number_mod_reduce
    import bignum_pkg::*;
#(
    parameter int Size_add        = SIZE_ADD,
    parameter int number_of_limbs = NUM_LIMBS,
    parameter int limb_size       = LIMB_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [Size_add-1:0] sum,
    input  logic [Size_add-1:0] modulus,
    output logic                busy,
    output logic [Size_add-1:0] r,
    output logic                en_out
);
    localparam int I_W = $clog2(number_of_limbs);
    localparam logic [I_W-1:0] LAST_IDX = I_W'(number_of_limbs - 1);

    fsm_state_t state, state_next;

    logic [number_of_limbs-1:0][limb_size-1:0] s_reg;
    logic [number_of_limbs-1:0][limb_size-1:0] m_reg;
    logic [number_of_limbs-1:0][limb_size-1:0] d_reg;
    logic [I_W-1:0]   idx;
    logic             borrow;
    logic [limb_size:0] d;

    // Single shared subtractor; operands selected by the current limb index.
    limb_subtractor #(.size(limb_size)) u_limb_sub (
        .a  (s_reg[idx]),
        .b  (m_reg[idx]),
        .bin(borrow),
        .d  (d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = SUB;
            SUB:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg  <= '0;
            m_reg  <= '0;
            d_reg  <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            r      <= '0;
            en_out <= 1'b0;
            busy   <= 1'b0;
        end else begin
            en_out <= (state == DONE);
            busy   <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (en) begin
                        s_reg  <= sum;
                        m_reg  <= modulus;
                        borrow <= 1'b0;
                        idx    <= '0;
                    end
                end
                SUB: begin
                    d_reg[idx] <= d[limb_size-1:0];
                    borrow     <= d[limb_size];
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                DONE: begin
                    // Final borrow set means sum < modulus: keep the original value.
                    r <= borrow ? s_reg : d_reg;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_big_number_mod_reduce.sv
// Directed and random bench for big_number_mod_reduce with an expected-result queue.
module tb_big_number_mod_reduce;
    import bignum_pkg::*;

    typedef struct {
        logic [SIZE_ADD-1:0] r;
        int                  cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic [SIZE_ADD-1:0] sum = '0;
    logic [SIZE_ADD-1:0] modulus = '0;
    logic                busy;
    logic [SIZE_ADD-1:0] r;
    logic                en_out;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   busy_cnt = 0;

    always #5 clk = ~clk;

    big_number_mod_reduce dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .sum    (sum),
        .modulus(modulus),
        .busy   (busy),
        .r      (r),
        .en_out (en_out)
    );

    function automatic logic [SIZE_ADD-1:0] rnd();
        logic [SIZE_ADD-1:0] v;
        for (int i = 0; i < SIZE_ADD / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_w(input string tag, input logic [SIZE_ADD-1:0] obs, input logic [SIZE_ADD-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (en_out === 1'b1) begin
            n_out++;
            if (sb.size() == 0) begin
                check_i("unexpected_en_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check_w("result", r, e.r);
                check_i("latency", cyc - e.cyc, 14);
            end
        end
    endtask

    task automatic start(input logic [SIZE_ADD-1:0] s, input logic [SIZE_ADD-1:0] m,
                         input logic [SIZE_ADD-1:0] exp_r, input bit accept);
        exp_t e;
        en = 1'b1;
        sum = s;
        modulus = m;
        tick();
        en = 1'b0;
        sum = rnd();
        modulus = rnd();
        if (accept) begin
            e.r = exp_r;
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check_i({tag, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    function automatic logic [SIZE_ADD-1:0] reduce_ref(input logic [SIZE_ADD-1:0] s, input logic [SIZE_ADD-1:0] m);
        return (s >= m) ? s - m : s;
    endfunction

    initial begin
        logic [SIZE_ADD-1:0] one, a, b, m, s;
        int n0;
        one = 1;

        // Reset with garbage on the inputs
        sum = rnd();
        modulus = rnd();
        en = 1'b1;
        repeat (3) tick();
        check_w("reset_r", r, '0);
        check_i("reset_en_out", int'(en_out), 0);
        check_i("reset_busy", int'(busy), 0);
        en = 1'b0;
        rst_n = 1'b1;
        n0 = n_out;
        repeat (50) tick();
        check_i("idle_no_en_out", n_out - n0, 0);

        // Basic reduction, with busy width measured on the first one
        busy_cnt = 0;
        start(1500, 1000, 500, 1);
        wait_done("basic_1500");
        check_i("busy_cycles", busy_cnt, 14);
        check_i("busy_low_after", int'(busy), 0);
        start(999, 1000, 999, 1);
        wait_done("basic_999");
        start(1000, 1000, 0, 1);
        wait_done("basic_1000");

        // Borrow across limbs
        start(one << 256, 1, (one << 256) - 1, 1);
        wait_done("xlimb_borrow");
        start(one << 3326, (one << 3326) + 1, one << 3326, 1);
        wait_done("final_borrow");

        // Second en while busy is dropped
        n0 = n_out;
        start(1500, 1000, 500, 1);
        repeat (4) tick();
        start(7, 1000, 7, 0);
        wait_done("collision");
        repeat (20) tick();
        check_i("collision_one_out", n_out - n0, 1);
        check_w("collision_r_held", r, 500);

        // Back-to-back: reissue in the en_out cycle
        n0 = n_out;
        start(2500, 2000, 500, 1);
        for (int i = 0; i < 40 && n_out == n0; i++) tick();
        check_i("b2b_first_out", n_out - n0, 1);
        start(123, 2000, 123, 1);
        wait_done("b2b_second");

        // Reset mid-operation aborts
        start(5000, 3000, 2000, 1);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check_w("abort_r", r, '0);
        check_i("abort_busy", int'(busy), 0);
        check_i("abort_en_out", int'(en_out), 0);
        sb.delete();
        n0 = n_out;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check_i("abort_no_en_out", n_out - n0, 0);
        start(77, 50, 27, 1);
        wait_done("after_abort");

        // Random modular additions (a + b) mod M with a, b < M
        for (int t = 0; t < 1000; t++) begin
            m = rnd();
            m[SIZE_ADD-1] = 1'b0;
            m = m >> $urandom_range(0, SIZE_ADD - 2);
            if (m == 0) m = 1;
            a = rnd() % m;
            b = rnd() % m;
            s = a + b;
            start(s, m, (a + b) % m, 1);
            wait_done("random");
        end
        check_w("random_ref_sanity", reduce_ref(s, m), r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
